mcb_port_arbiter: RTL and testbench

Shares a single MCB user port between two requesters: port A, the scan-out path of `hdmi_video`, which only reads, and port B, a general read/write client such as the host framebuffer writer. The block has four jobs:
- arbitrate the command path, with fixed priority to A and a starvation guard for B;
- pass B's write data through to the MCB;
- track outstanding reads in a tag FIFO;
- route returned read words to the requester that issued them.

It sits between both clients and the MCB port pins.

---
 rtl/mcb_port_arbiter_if.sv | 68 ++++++
 rtl/mcb_port_arbiter.sv | 129 ++++++++++++
 tb/tb_mcb_port_arbiter.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/mcb_port_arbiter_if.sv
// Client and MCB-side signal bundle for mcb_port_arbiter.
// The slave modport is the arbiter's view; master is the surrounding system's view.
interface mcb_port_arbiter_if;
  logic        a_cmd_en_in;
  logic [5:0]  a_cmd_bl_in;
  logic [29:0] a_cmd_byte_addr_in;
  logic        a_cmd_ready_out;
  logic [63:0] a_rd_data_out;
  logic        a_rd_valid_out;

  logic        b_cmd_en_in;
  logic [2:0]  b_cmd_instr_in;
  logic [5:0]  b_cmd_bl_in;
  logic [29:0] b_cmd_byte_addr_in;
  logic        b_cmd_ready_out;
  logic        b_wr_en_in;
  logic [7:0]  b_wr_mask_in;
  logic [63:0] b_wr_data_in;
  logic        b_wr_full_out;
  logic [63:0] b_rd_data_out;
  logic        b_rd_valid_out;

  logic        mcb_cmd_en_out;
  logic [2:0]  mcb_cmd_instr_out;
  logic [5:0]  mcb_cmd_bl_out;
  logic [29:0] mcb_cmd_byte_addr_out;
  logic        mcb_cmd_full_in;
  logic        mcb_wr_en_out;
  logic [7:0]  mcb_wr_mask_out;
  logic [63:0] mcb_wr_data_out;
  logic        mcb_wr_full_in;
  logic        mcb_rd_en_out;
  logic [63:0] mcb_rd_data_in;
  logic        mcb_rd_empty_in;
  logic        error_out;

  modport slave (
    input  a_cmd_en_in, a_cmd_bl_in, a_cmd_byte_addr_in,
    output a_cmd_ready_out, a_rd_data_out, a_rd_valid_out,
    input  b_cmd_en_in, b_cmd_instr_in, b_cmd_bl_in, b_cmd_byte_addr_in,
    output b_cmd_ready_out,
    input  b_wr_en_in, b_wr_mask_in, b_wr_data_in,
    output b_wr_full_out, b_rd_data_out, b_rd_valid_out,
    output mcb_cmd_en_out, mcb_cmd_instr_out, mcb_cmd_bl_out, mcb_cmd_byte_addr_out,
    input  mcb_cmd_full_in,
    output mcb_wr_en_out, mcb_wr_mask_out, mcb_wr_data_out,
    input  mcb_wr_full_in,
    output mcb_rd_en_out,
    input  mcb_rd_data_in, mcb_rd_empty_in,
    output error_out
  );

  modport master (
    output a_cmd_en_in, a_cmd_bl_in, a_cmd_byte_addr_in,
    input  a_cmd_ready_out, a_rd_data_out, a_rd_valid_out,
    output b_cmd_en_in, b_cmd_instr_in, b_cmd_bl_in, b_cmd_byte_addr_in,
    input  b_cmd_ready_out,
    output b_wr_en_in, b_wr_mask_in, b_wr_data_in,
    input  b_wr_full_out, b_rd_data_out, b_rd_valid_out,
    input  mcb_cmd_en_out, mcb_cmd_instr_out, mcb_cmd_bl_out, mcb_cmd_byte_addr_out,
    output mcb_cmd_full_in,
    input  mcb_wr_en_out, mcb_wr_mask_out, mcb_wr_data_out,
    output mcb_wr_full_in,
    input  mcb_rd_en_out,
    output mcb_rd_data_in, mcb_rd_empty_in,
    input  error_out
  );
endinterface

// File: rtl/mcb_port_arbiter.sv
// Two-client arbiter for one MCB user port: A (read-only, priority) and B (read/write),
// with a starvation guard for B and a tag FIFO that routes read words back to their issuer.
module mcb_port_arbiter #(
  parameter int TAG_DEPTH  = 8,
  parameter int STARVE_MAX = 16
) (
  input  logic              clk,
  input  logic              rst,
  mcb_port_arbiter_if.slave bus
);
  localparam int PW = $clog2(TAG_DEPTH);
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [PW:0]   DEPTH_V  = (PW + 1)'(TAG_DEPTH);
  localparam logic [SW-1:0] STARVE_V = SW'(STARVE_MAX);

  logic [PW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic          tag_owner_q [TAG_DEPTH];
  logic [5:0]    tag_bl_q    [TAG_DEPTH];
  logic [5:0]    word_q, word_d;
  logic [SW-1:0] starve_q, starve_d;

  logic          cmd_en_q;
  logic [2:0]    cmd_instr_q;
  logic [5:0]    cmd_bl_q;
  logic [29:0]   cmd_addr_q;
  logic [63:0]   a_data_q, b_data_q;
  logic          a_valid_q, b_valid_q, err_q;

  logic tag_full, tag_nonempty, head_owner;
  logic [5:0] head_bl;
  logic cmd_elig, b_is_rd, a_elig, b_req, force_b, a_grant, b_grant;
  logic push, rd_pop, last_word;

  assign tag_nonempty = (wr_ptr_q != rd_ptr_q);
  assign tag_full     = ((wr_ptr_q - rd_ptr_q) == DEPTH_V);
  assign head_owner   = tag_owner_q[rd_ptr_q[PW-1:0]];
  assign head_bl      = tag_bl_q[rd_ptr_q[PW-1:0]];

  // Issue slot is only free when the previous command is no longer on the pins.
  assign cmd_elig = !bus.mcb_cmd_full_in && !cmd_en_q;
  assign b_is_rd  = bus.b_cmd_instr_in[0];
  assign a_elig   = cmd_elig && !tag_full;
  assign b_req    = bus.b_cmd_en_in && cmd_elig && (!b_is_rd || !tag_full);
  assign force_b  = (starve_q == STARVE_V) && b_req;
  assign a_grant  = bus.a_cmd_en_in && a_elig && !force_b;
  assign b_grant  = b_req && !a_grant;

  assign push      = a_grant || (b_grant && b_is_rd);
  assign rd_pop    = !bus.mcb_rd_empty_in && tag_nonempty;
  assign last_word = rd_pop && (word_q == head_bl);

  always_comb begin
    starve_d = starve_q;
    if (!bus.b_cmd_en_in || b_grant)
      starve_d = '0;
    else if (a_grant && starve_q != STARVE_V)
      starve_d = starve_q + 1'b1;
    wr_ptr_d = wr_ptr_q + (PW + 1)'(push);
    rd_ptr_d = rd_ptr_q + (PW + 1)'(last_word);
    word_d   = word_q;
    if (last_word)
      word_d = '0;
    else if (rd_pop)
      word_d = word_q + 6'd1;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      tag_owner_q[wr_ptr_q[PW-1:0]] <= b_grant;
      tag_bl_q[wr_ptr_q[PW-1:0]]    <= a_grant ? bus.a_cmd_bl_in : bus.b_cmd_bl_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      word_q      <= '0;
      starve_q    <= '0;
      cmd_en_q    <= 1'b0;
      cmd_instr_q <= '0;
      cmd_bl_q    <= '0;
      cmd_addr_q  <= '0;
      a_data_q    <= '0;
      b_data_q    <= '0;
      a_valid_q   <= 1'b0;
      b_valid_q   <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      word_q    <= word_d;
      starve_q  <= starve_d;
      cmd_en_q  <= a_grant || b_grant;
      a_valid_q <= rd_pop && !head_owner;
      b_valid_q <= rd_pop && head_owner;
      if (a_grant) begin
        cmd_instr_q <= 3'b001;
        cmd_bl_q    <= bus.a_cmd_bl_in;
        cmd_addr_q  <= bus.a_cmd_byte_addr_in;
      end else if (b_grant) begin
        cmd_instr_q <= bus.b_cmd_instr_in;
        cmd_bl_q    <= bus.b_cmd_bl_in;
        cmd_addr_q  <= bus.b_cmd_byte_addr_in;
      end
      if (rd_pop && !head_owner) a_data_q <= bus.mcb_rd_data_in;
      if (rd_pop && head_owner)  b_data_q <= bus.mcb_rd_data_in;
      // Data with nothing outstanding is left in the MCB FIFO and flagged.
      if (!bus.mcb_rd_empty_in && !tag_nonempty) err_q <= 1'b1;
    end
  end

  assign bus.a_cmd_ready_out       = a_grant;
  assign bus.b_cmd_ready_out       = b_grant;
  assign bus.a_rd_data_out         = a_data_q;
  assign bus.a_rd_valid_out        = a_valid_q;
  assign bus.b_rd_data_out         = b_data_q;
  assign bus.b_rd_valid_out        = b_valid_q;
  assign bus.mcb_cmd_en_out        = cmd_en_q;
  assign bus.mcb_cmd_instr_out     = cmd_instr_q;
  assign bus.mcb_cmd_bl_out        = cmd_bl_q;
  assign bus.mcb_cmd_byte_addr_out = cmd_addr_q;
  assign bus.mcb_wr_en_out         = bus.b_wr_en_in && !bus.mcb_wr_full_in;
  assign bus.mcb_wr_mask_out       = bus.b_wr_mask_in;
  assign bus.mcb_wr_data_out       = bus.b_wr_data_in;
  assign bus.b_wr_full_out         = bus.mcb_wr_full_in;
  assign bus.mcb_rd_en_out         = rd_pop;
  assign bus.error_out             = err_q;
endmodule

// File: tb/tb_mcb_port_arbiter.sv
// Directed bench for mcb_port_arbiter: a vector table for the combinational grant and
// write paths, plus hand-written sequences for issue, routing, starvation, tag-full and error.
module tb_mcb_port_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_pass = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  mcb_port_arbiter_if bus_if ();

  mcb_port_arbiter #(.TAG_DEPTH(8), .STARVE_MAX(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  typedef struct {
    logic       a_en;
    logic       b_en;
    logic [2:0] b_instr;
    logic       cmd_full;
    logic       wr_en;
    logic       wr_full;
    logic       exp_a_rdy;
    logic       exp_b_rdy;
    logic       exp_wr_en;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    else begin
      n_pass++;
      $display("ok   %s = %0h", name, act);
    end
  endtask

  // Issue one A read; checks acceptance, the one-cycle command pulse and its fields.
  task automatic issue_a(input logic [5:0] bl, input logic [29:0] addr);
    @(negedge clk);
    bus_if.a_cmd_en_in = 1'b1;
    bus_if.a_cmd_bl_in = bl;
    bus_if.a_cmd_byte_addr_in = addr;
    #1 chk("a_ready", bus_if.a_cmd_ready_out, 1'b1);
    @(posedge clk);
    #1 bus_if.a_cmd_en_in = 1'b0;
    chk("a_cmd_en", bus_if.mcb_cmd_en_out, 1'b1);
    chk("a_cmd_instr", bus_if.mcb_cmd_instr_out, 3'b001);
    chk("a_cmd_bl", bus_if.mcb_cmd_bl_out, bl);
    chk("a_cmd_addr", bus_if.mcb_cmd_byte_addr_out, addr);
    @(posedge clk);
    #1 chk("a_cmd_en_drop", bus_if.mcb_cmd_en_out, 1'b0);
  endtask

  task automatic issue_b(input logic [2:0] instr, input logic [5:0] bl, input logic [29:0] addr);
    @(negedge clk);
    bus_if.b_cmd_en_in = 1'b1;
    bus_if.b_cmd_instr_in = instr;
    bus_if.b_cmd_bl_in = bl;
    bus_if.b_cmd_byte_addr_in = addr;
    #1 chk("b_ready", bus_if.b_cmd_ready_out, 1'b1);
    @(posedge clk);
    #1 bus_if.b_cmd_en_in = 1'b0;
    chk("b_cmd_en", bus_if.mcb_cmd_en_out, 1'b1);
    chk("b_cmd_instr", bus_if.mcb_cmd_instr_out, instr);
    chk("b_cmd_addr", bus_if.mcb_cmd_byte_addr_out, addr);
    @(posedge clk);
  endtask

  // Present one word from the MCB; it must be popped and land at the named owner next cycle.
  task automatic pop_word(input logic [63:0] d, input logic to_b);
    @(negedge clk);
    bus_if.mcb_rd_data_in = d;
    bus_if.mcb_rd_empty_in = 1'b0;
    #1 chk("rd_en", bus_if.mcb_rd_en_out, 1'b1);
    @(posedge clk);
    #1 bus_if.mcb_rd_empty_in = 1'b1;
    chk("a_valid", bus_if.a_rd_valid_out, !to_b);
    chk("b_valid", bus_if.b_rd_valid_out, to_b);
    chk(to_b ? "b_data" : "a_data", to_b ? bus_if.b_rd_data_out : bus_if.a_rd_data_out, d);
  endtask

  vec_t vecs[7];
  int   pending, a_grants;
  logic b_got, both_high;

  initial begin
    bus_if.a_cmd_en_in = 0; bus_if.a_cmd_bl_in = 0; bus_if.a_cmd_byte_addr_in = 0;
    bus_if.b_cmd_en_in = 0; bus_if.b_cmd_instr_in = 0; bus_if.b_cmd_bl_in = 0;
    bus_if.b_cmd_byte_addr_in = 0; bus_if.b_wr_en_in = 0; bus_if.b_wr_mask_in = 0;
    bus_if.b_wr_data_in = 0; bus_if.mcb_cmd_full_in = 0; bus_if.mcb_wr_full_in = 0;
    bus_if.mcb_rd_data_in = 0; bus_if.mcb_rd_empty_in = 1;

    vecs[0] = '{1, 0, 3'b000, 0, 0, 0, 1, 0, 0};
    vecs[1] = '{0, 1, 3'b001, 0, 0, 0, 0, 1, 0};
    vecs[2] = '{1, 1, 3'b000, 0, 0, 0, 1, 0, 0};
    vecs[3] = '{1, 1, 3'b001, 1, 0, 0, 0, 0, 0};
    vecs[4] = '{0, 1, 3'b100, 0, 1, 0, 0, 1, 1};
    vecs[5] = '{0, 0, 3'b000, 0, 1, 1, 0, 0, 0};
    vecs[6] = '{0, 0, 3'b010, 0, 1, 0, 0, 0, 1};

    #1;
    chk("rst_cmd_en", bus_if.mcb_cmd_en_out, 1'b0);
    chk("rst_a_valid", bus_if.a_rd_valid_out, 1'b0);
    chk("rst_b_valid", bus_if.b_rd_valid_out, 1'b0);
    chk("rst_error", bus_if.error_out, 1'b0);
    chk("rst_rd_en", bus_if.mcb_rd_en_out, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    // Combinational vectors: inputs are withdrawn before the edge so nothing is committed.
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      bus_if.a_cmd_en_in = vecs[i].a_en;
      bus_if.b_cmd_en_in = vecs[i].b_en;
      bus_if.b_cmd_instr_in = vecs[i].b_instr;
      bus_if.mcb_cmd_full_in = vecs[i].cmd_full;
      bus_if.b_wr_en_in = vecs[i].wr_en;
      bus_if.mcb_wr_full_in = vecs[i].wr_full;
      bus_if.b_wr_data_in = 64'hDEAD_BEEF_0000_0000 + 64'(i);
      bus_if.b_wr_mask_in = 8'(8'h5A ^ i);
      #1;
      chk($sformatf("v%0d_a_ready", i), bus_if.a_cmd_ready_out, vecs[i].exp_a_rdy);
      chk($sformatf("v%0d_b_ready", i), bus_if.b_cmd_ready_out, vecs[i].exp_b_rdy);
      chk($sformatf("v%0d_wr_en", i), bus_if.mcb_wr_en_out, vecs[i].exp_wr_en);
      chk($sformatf("v%0d_wr_full", i), bus_if.b_wr_full_out, vecs[i].wr_full);
      chk($sformatf("v%0d_wr_data", i), bus_if.mcb_wr_data_out, 64'hDEAD_BEEF_0000_0000 + 64'(i));
      chk($sformatf("v%0d_wr_mask", i), bus_if.mcb_wr_mask_out, 8'(8'h5A ^ i));
      bus_if.a_cmd_en_in = 0; bus_if.b_cmd_en_in = 0; bus_if.b_wr_en_in = 0;
      bus_if.mcb_cmd_full_in = 0; bus_if.mcb_wr_full_in = 0;
    end

    // Single A read, 4-word burst.
    issue_a(6'd3, 30'h100);
    for (int k = 0; k < 4; k++) pop_word(64'(k), 1'b0);

    // Contention: A wins, B write issues two cycles later.
    @(negedge clk);
    bus_if.a_cmd_en_in = 1; bus_if.a_cmd_bl_in = 0; bus_if.a_cmd_byte_addr_in = 30'h200;
    bus_if.b_cmd_en_in = 1; bus_if.b_cmd_instr_in = 3'b000; bus_if.b_cmd_bl_in = 5;
    bus_if.b_cmd_byte_addr_in = 30'h300;
    #1 chk("cont_a_ready", bus_if.a_cmd_ready_out, 1'b1);
    chk("cont_b_ready", bus_if.b_cmd_ready_out, 1'b0);
    @(posedge clk);
    #1 bus_if.a_cmd_en_in = 0;
    chk("cont_b_wait", bus_if.b_cmd_ready_out, 1'b0);
    chk("cont_a_addr", bus_if.mcb_cmd_byte_addr_out, 30'h200);
    @(posedge clk);
    #1 chk("cont_b_ready2", bus_if.b_cmd_ready_out, 1'b1);
    @(posedge clk);
    #1 bus_if.b_cmd_en_in = 0;
    chk("cont_b_cmd_en", bus_if.mcb_cmd_en_out, 1'b1);
    chk("cont_b_instr", bus_if.mcb_cmd_instr_out, 3'b000);
    chk("cont_b_addr", bus_if.mcb_cmd_byte_addr_out, 30'h300);
    pop_word(64'h55, 1'b0);

    // Interleaved routing across a tag boundary.
    issue_a(6'd1, 30'h400);
    issue_b(3'b001, 6'd0, 30'h500);
    pop_word(64'hA, 1'b0);
    pop_word(64'hB, 1'b0);
    pop_word(64'hC, 1'b1);

    // Starvation guard: pending mirrors outstanding single-word reads so data is only offered when owed.
    pending = 0; a_grants = 0; b_got = 0; both_high = 0;
    bus_if.a_cmd_en_in = 1; bus_if.a_cmd_bl_in = 0; bus_if.a_cmd_byte_addr_in = 30'h600;
    bus_if.b_cmd_en_in = 1; bus_if.b_cmd_instr_in = 3'b001; bus_if.b_cmd_bl_in = 0;
    bus_if.b_cmd_byte_addr_in = 30'h700;
    for (int cyc = 0; cyc < 100 && !b_got; cyc++) begin
      @(negedge clk);
      bus_if.mcb_rd_data_in = 64'h77;
      bus_if.mcb_rd_empty_in = (pending == 0);
      #1;
      if (bus_if.a_cmd_ready_out && bus_if.b_cmd_ready_out) both_high = 1;
      if (bus_if.a_cmd_ready_out) begin a_grants++; pending++; end
      if (bus_if.b_cmd_ready_out) begin b_got = 1; pending++; end
      if (bus_if.mcb_rd_en_out) pending--;
    end
    @(posedge clk);
    #1 bus_if.a_cmd_en_in = 0; bus_if.b_cmd_en_in = 0; bus_if.mcb_rd_empty_in = 1;
    chk("starve_b_granted", b_got, 1'b1);
    chk("starve_a_grants", a_grants, 16);
    chk("starve_exclusive", both_high, 1'b0);
    chk("starve_pending", pending, 1);
    chk("starve_b_instr", bus_if.mcb_cmd_instr_out, 3'b001);
    pop_word(64'h88, 1'b1);

    // Tag full: eight outstanding A reads block A and B reads, not a B write.
    for (int k = 0; k < 8; k++) issue_a(6'd1, 30'(32'h800 + k * 16));
    @(negedge clk);
    bus_if.a_cmd_en_in = 1; bus_if.b_cmd_en_in = 1; bus_if.b_cmd_instr_in = 3'b001;
    #1 chk("full_a_ready", bus_if.a_cmd_ready_out, 1'b0);
    chk("full_b_read", bus_if.b_cmd_ready_out, 1'b0);
    bus_if.b_cmd_instr_in = 3'b000; bus_if.b_cmd_byte_addr_in = 30'h900;
    #1 chk("full_b_write", bus_if.b_cmd_ready_out, 1'b1);
    @(posedge clk);
    #1 bus_if.a_cmd_en_in = 0; bus_if.b_cmd_en_in = 0;
    chk("full_b_cmd_en", bus_if.mcb_cmd_en_out, 1'b1);
    chk("full_b_addr", bus_if.mcb_cmd_byte_addr_out, 30'h900);
    pop_word(64'h1234, 1'b0);

    // Reset mid-burst.
    @(negedge clk);
    rst = 1'b1; bus_if.mcb_rd_empty_in = 0;
    #1 chk("mid_rst_a_valid", bus_if.a_rd_valid_out, 1'b0);
    chk("mid_rst_a_data", bus_if.a_rd_data_out, 64'h0);
    chk("mid_rst_rd_en", bus_if.mcb_rd_en_out, 1'b0);
    chk("mid_rst_cmd_instr", bus_if.mcb_cmd_instr_out, 3'b000);
    chk("mid_rst_cmd_addr", bus_if.mcb_cmd_byte_addr_out, 30'h0);
    bus_if.a_cmd_en_in = 1;
    #1 chk("mid_rst_tags_clear", bus_if.a_cmd_ready_out, 1'b1);
    bus_if.a_cmd_en_in = 0; bus_if.mcb_rd_empty_in = 1;
    @(negedge clk) rst = 1'b0;

    // Error: data with no outstanding tag.
    @(negedge clk);
    bus_if.mcb_rd_empty_in = 0;
    #1 chk("err_rd_en", bus_if.mcb_rd_en_out, 1'b0);
    chk("err_before", bus_if.error_out, 1'b0);
    @(posedge clk);
    #1 bus_if.mcb_rd_empty_in = 1;
    chk("err_set", bus_if.error_out, 1'b1);
    repeat (3) @(posedge clk);
    #1 chk("err_sticky", bus_if.error_out, 1'b1);
    rst = 1'b1;
    #1 chk("err_rst", bus_if.error_out, 1'b0);
    @(negedge clk) rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
